qtps_iq: RTL and testbench
==========================

Name: qtps_iq

Overview:
- Instruction queue IQ0 for the QTP-S core: a circular FIFO that accepts 32-bit QTP-S instruction words from the fetch/loader side and presents them in order to the qtps decode stage.
- This is the writer and producer end of the decode input.
- Provides a valid/ready handshake on both sides, a synchronous flush used on branch redirect, and occupancy status.
- Storage is a register array; no SRAM macro.

Parameters:
- DEPTH, 8, number of instruction entries; power of two, >= 2
- IW, INSTRUCTION_WIDTH (32), instruction word width, taken from qtpa_pkg

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous queue clear (branch/loop redirect)
- in_valid  input  1  producer offers in_instr
- in_instr  input  IW  instruction word to enqueue
- in_ready  output  1  queue can accept in_instr this cycle
- out_valid  output  1  out_instr holds the oldest valid entry
- out_instr  output  IW  head instruction, to the decode instruction input
- out_ready  input  1  decode consumes the head this cycle
- count  output  $clog2(DEPTH+1)  number of valid entries
- full  output  1  count == DEPTH
- empty  output  1  count == 0

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low, on clk and rst_n.
- Reset state (rst_n low, asynchronous):
  - wr_ptr, rd_ptr and count = 0.
  - out_valid = 0, in_ready = 1, full = 0, empty = 1, out_instr = 0.
  - Storage contents are don't-care.
- Handshakes:
  - Push occurs when in_valid && in_ready.
  - Pop occurs when out_valid && out_ready.
  - Both are evaluated at the same rising edge.
- Pointers:
  - wr_ptr and rd_ptr are log2(DEPTH) bits wide.
  - Each increments by 1 on push or pop respectively and wraps DEPTH-1 -> 0 naturally.
  - count tracks occupancy independently of the pointers, so full and empty are never ambiguous.
- Outputs:
  - out_valid = !empty && !flush.
  - out_instr = mem[rd_ptr] when !empty, else 0. All-zero output when empty is required so decode sees a deterministic word.
  - in_ready = !flush && (!full || out_ready). A push into a full queue is legal in the same cycle as a pop.
  - This makes in_ready combinationally dependent on out_ready. The decode side must not make out_ready depend on in_ready.
- Latency: a word pushed at edge N is visible on out_instr/out_valid after edge N (first-word fall-through through storage, 1 cycle). There is no bypass from in_instr to out_instr in the same cycle.
- Count update at each edge:
  - push only: +1
  - pop only: -1
  - both: unchanged, and both pointers advance
  - neither: unchanged
- Empty + push + out_ready: no pop occurs, because out_valid is 0. The entry appears next cycle.
- Full + push + pop: both occur and count stays at DEPTH. The new word lands in the slot just vacated (wr_ptr == rd_ptr before the edge).
- flush:
  - When high at an edge: pointers and count reset to 0 and storage is untouched.
  - Any simultaneous push or pop is suppressed (in_ready and out_valid are forced 0 while flush is high).
  - Flush has priority over all other activity.
- Asynchronous reset mid-operation clears state immediately, regardless of clk.
- No error outputs: overflow and underflow are impossible by construction of in_ready/out_valid.
- Assertions (bench): no push when !in_ready; count <= DEPTH; in_instr stable while in_valid && !in_ready is the producer's obligation and is checked.

Test Plan:
- Reset then fill: push 0x04000001..0x04000008 (DEPTH=8) with out_ready=0 -> count 1..8; full=1 and in_ready=0 after 8th push; out_instr=0x04000001 from cycle after first push.
- Drain order: from full, hold out_ready=1, in_valid=0 -> out_instr sequence 0x04000001..0x04000008 on consecutive cycles; empty=1, out_valid=0, out_instr=0 after 8th pop.
- Full push+pop: queue full, in_valid=1 with 0xDEADBEEF, out_ready=1 -> in_ready=1, count stays 8, 0xDEADBEEF emerges as 8th word after the current head; verify pointer wrap past index 7.
- Flush priority: 5 entries, assert flush with in_valid=1, out_ready=1 -> in_ready=0 and out_valid=0 that cycle; next cycle count=0, empty=1; the word offered during flush is not enqueued.
- Async reset mid-stream: 3 entries, drop rst_n between clock edges -> count=0, out_valid=0, in_ready=1 immediately, without waiting for a clk edge; after release, first push 0x12345678 appears next cycle.
- Random stress: 10k cycles of random in_valid/out_ready/flush (flush at 2%) against a scoreboard queue model -> exact order match, no assertion failures.

Source files
------------

// File: rtl/qtps_iq.sv
// QTP-S instruction queue IQ0: a register-array circular FIFO between fetch/loader and decode.
// The queue has a valid/ready handshake on both sides, a synchronous flush for redirects, and occupancy status.

package qtpa_pkg;
    localparam int INSTRUCTION_WIDTH = 32;
endpackage

module qtps_iq #(
    parameter int DEPTH = 8,
    parameter int IW    = qtpa_pkg::INSTRUCTION_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [IW-1:0]              in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [IW-1:0]              out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [IW-1:0] mem_q [DEPTH];
    logic [IW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    // A push into a full queue is accepted when the head leaves on the same edge.
    always_comb begin
        full      = (count_q == CNT_FULL);
        empty     = (count_q == '0);
        out_valid = !empty && !flush;
        in_ready  = !flush && (!full || out_ready);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_instr = empty ? '0 : mem_q[rd_ptr_q];
        count     = count_q;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_instr;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the empty-gated read mux hides stale contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_qtps_iq.sv
// Self-checking bench for qtps_iq.
// It applies table vectors, hand-written corner sequences, and random traffic checked against a queue model.

module tb_qtps_iq;

    localparam int DEPTH = 8;
    localparam int IW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [IW-1:0] in_instr;
    logic          in_ready;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    int checks   = 0;
    int failures = 0;

    qtps_iq #(.DEPTH(DEPTH), .IW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic f, input logic iv, input logic [31:0] ii, input logic ordy);
        flush     = f;
        in_valid  = iv;
        in_instr  = ii;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int e_cnt, input logic e_ov,
                             input logic [31:0] e_oi, input logic e_ir);
        chk({tag, "_count"}, 32'(count), 32'(e_cnt));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(e_ov));
        chk({tag, "_out_instr"}, out_instr, e_oi);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(e_ir));
        chk({tag, "_full"}, 32'(full), 32'(e_cnt == DEPTH));
        chk({tag, "_empty"}, 32'(empty), 32'(e_cnt == 0));
    endtask

    // Protocol monitor: inputs are stable from posedge+1 until the next posedge.
    logic          armed = 1'b0;
    logic          p_stall;
    logic          p_ir;
    logic [31:0]   p_instr;
    logic [CW-1:0] p_count;

    always @(negedge clk) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            chk("count_le_depth", 32'(count <= CW'(DEPTH)), 32'd1);
            if (armed && p_stall && in_valid)
                chk("in_instr_stable_while_stalled", in_instr, p_instr);
            if (armed && !p_ir)
                chk("no_push_when_not_ready", 32'(count <= p_count), 32'd1);
            armed   <= 1'b1;
            p_stall <= in_valid && !in_ready;
            p_ir    <= in_ready;
            p_instr <= in_instr;
            p_count <= count;
        end
    end

    typedef struct {
        logic        f;
        logic        iv;
        logic [31:0] ii;
        logic        ordy;
        int          e_cnt;
        logic        e_ov;
        logic [31:0] e_oi;
        logic        e_ir;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic f, logic iv, logic [31:0] ii, logic ordy,
                                int e_cnt, logic e_ov, logic [31:0] e_oi, logic e_ir);
        vec_t v;
        v.f = f; v.iv = iv; v.ii = ii; v.ordy = ordy;
        v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_oi = e_oi; v.e_ir = e_ir;
        return v;
    endfunction

    logic [31:0] mq[$];

    initial begin
        logic [31:0] base;
        logic        m_ir;
        logic        m_ov;
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [31:0] ii;
        logic        stalled;

        base = 32'h0400_0001;
        // Fill with the head stalled, then hit full.
        for (int i = 0; i < DEPTH; i++)
            tbl.push_back(mk(1'b0, 1'b1, base + 32'(i), 1'b0, i, i > 0, (i > 0) ? base : 32'h0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, DEPTH, 1'b1, base, 1'b0));
        // Push and pop together while full.
        tbl.push_back(mk(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, DEPTH, 1'b1, base, 1'b1));
        // Drain the queue; DEADBEEF comes out eighth, after both pointers wrap.
        for (int i = 0; i < DEPTH; i++)
            tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, DEPTH - i, 1'b1,
                             (i < DEPTH - 1) ? base + 32'(i + 1) : 32'hDEAD_BEEF, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b0, 32'h0, 1'b1));
        // Push into an empty queue with out_ready high: no pop, no bypass.
        tbl.push_back(mk(1'b0, 1'b1, 32'hCAFE_0001, 1'b1, 0, 1'b0, 32'h0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1, 32'hCAFE_0001, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b1));

        // Reset
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #3;
        chk_state("reset", 0, 1'b0, 32'h0, 1'b1);
        #9 rst_n = 1'b1;
        tick();

        foreach (tbl[k]) begin
            drive(tbl[k].f, tbl[k].iv, tbl[k].ii, tbl[k].ordy);
            #1;
            chk_state($sformatf("vec%0d", k), tbl[k].e_cnt, tbl[k].e_ov, tbl[k].e_oi, tbl[k].e_ir);
            tick();
        end

        // Flush priority with five entries.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 32'hA000_0000 + 32'(i), 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 32'h5555_5555, 1'b1);
        #1;
        chk("flush_count_before", 32'(count), 32'd5);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk_state("after_flush", 0, 1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b0, 1'b1, 32'h7777_0001, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk_state("post_flush_push", 1, 1'b1, 32'h7777_0001, 1'b1);
        tick();

        // Asynchronous reset between clock edges.
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        chk("pre_areset_pop", 32'(out_valid), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'hB000_0001 + 32'(i), 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("areset_count_before", 32'(count), 32'd3);
        rst_n = 1'b0;
        #1;
        chk_state("areset", 0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 32'h1234_5678, 1'b0);
        #1;
        chk("areset_no_bypass", 32'(out_valid), 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk_state("areset_first_push", 1, 1'b1, 32'h1234_5678, 1'b1);
        tick();

        // Random stress against the queue model, starting from a flushed queue.
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        mq.delete();
        stalled = 1'b0;
        iv = 1'b0;
        ii = 32'h0;
        for (int c = 0; c < 10000; c++) begin
            fl   = ($urandom_range(99) < 2);
            ordy = 1'($urandom_range(1));
            if (!stalled) begin
                iv = 1'($urandom_range(1));
                ii = $urandom;
            end
            drive(fl, iv, ii, ordy);
            #1;
            m_ov = (mq.size() > 0) && !fl;
            m_ir = !fl && ((mq.size() < DEPTH) || ordy);
            chk_state("rand", mq.size(), m_ov, (mq.size() > 0) ? mq[0] : 32'h0, m_ir);
            if (fl) begin
                mq.delete();
            end else begin
                if (m_ov && ordy) void'(mq.pop_front());
                if (iv && m_ir) mq.push_back(ii);
            end
            stalled = iv && !m_ir;
            tick();
        end

        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
